// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/DM memory port arbiter: FSM states and owner encoding.
package mem_arb_pkg;

  // Bus widths track the core's instruction/data word definitions.
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating counter of IF requests passed over in favour of DM; sat_o forces an IF grant.
module arb_starve_ctr #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != W'(MAX))) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign sat_o = (cnt_q == W'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (IF) and load/store (DM), one access in flight,
// DM priority with an IF starvation guard, fixed memory read latency.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              dm_req_valid,
  input  logic              dm_req_we,
  input  logic [ADDR_W-1:0] dm_req_addr,
  input  logic [DATA_W-1:0] dm_req_wdata,
  output logic              dm_req_ready,
  output logic              dm_rsp_valid,
  output logic [DATA_W-1:0] dm_rsp_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
    $error("mem_port_arbiter: MEM_LAT must be in 1..15");
  end
  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("mem_port_arbiter: STARVE_MAX must be >= 1");
  end

  arb_state_e        state_q;
  logic              owner_q;
  logic              we_q;
  logic [3:0]        lat_cnt_q;
  logic              mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              if_rsp_valid_q, dm_rsp_valid_q;
  logic [DATA_W-1:0] if_rsp_data_q, dm_rsp_data_q;

  // Handshake: a request transfers in the cycle where valid and ready are both 1. Ready is
  // combinational, only asserted in IDLE and only to the arbitration winner; requesters hold
  // valid and payload until ready, and may drop valid before ready without effect.
  logic starve_sat, idle, if_win, dm_win, if_grant, dm_grant;

  assign idle         = rst_n && (state_q == IDLE);
  assign if_win       = if_req_valid && (starve_sat || !dm_req_valid);
  assign dm_win       = dm_req_valid && !if_win;
  assign if_req_ready = idle && if_win;
  assign dm_req_ready = idle && dm_win;
  assign if_grant     = if_req_valid && if_req_ready;
  assign dm_grant     = dm_req_valid && dm_req_ready;

  arb_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (dm_grant && if_req_valid),
    .clr_i (if_grant),
    .sat_o (starve_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      owner_q        <= OWN_IF;
      we_q           <= 1'b0;
      lat_cnt_q      <= '0;
      mem_en_q       <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      if_rsp_valid_q <= 1'b0;
      dm_rsp_valid_q <= 1'b0;
      if_rsp_data_q  <= '0;
      dm_rsp_data_q  <= '0;
    end else begin
      if_rsp_valid_q <= 1'b0;
      dm_rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (if_grant || dm_grant) begin
            owner_q     <= dm_grant ? OWN_DM : OWN_IF;
            we_q        <= dm_grant && dm_req_we;
            mem_en_q    <= 1'b1;
            mem_we_q    <= dm_grant && dm_req_we;
            mem_addr_q  <= dm_grant ? dm_req_addr : if_req_addr;
            mem_wdata_q <= (dm_grant && dm_req_we) ? dm_req_wdata : '0;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          // The memory strobe and its payload are only ever visible for this one cycle.
          mem_en_q    <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          lat_cnt_q   <= 4'(MEM_LAT);
          state_q     <= WAIT;
        end
        WAIT: begin
          lat_cnt_q <= lat_cnt_q - 4'd1;
          if (lat_cnt_q == 4'd1) begin
            if (owner_q == OWN_DM) begin
              dm_rsp_data_q  <= we_q ? '0 : mem_rdata;
              dm_rsp_valid_q <= 1'b1;
            end else begin
              if_rsp_data_q  <= mem_rdata;
              if_rsp_valid_q <= 1'b1;
            end
            state_q <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign if_rsp_valid = if_rsp_valid_q;
  assign if_rsp_data  = if_rsp_data_q;
  assign dm_rsp_valid = dm_rsp_valid_q;
  assign dm_rsp_data  = dm_rsp_data_q;
  assign mem_en       = mem_en_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign busy         = (state_q != IDLE);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: main instance at MEM_LAT=2, plus MEM_LAT=1/15 instances.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- main DUT (MEM_LAT=2) ----------------
  logic        if_req_valid = 1'b0;
  logic [31:0] if_req_addr = '0;
  logic        if_req_ready, if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        dm_req_valid = 1'b0, dm_req_we = 1'b0;
  logic [31:0] dm_req_addr = '0, dm_req_wdata = '0;
  logic        dm_req_ready, dm_rsp_valid;
  logic [31:0] dm_rsp_data;
  logic        mem_en, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  dbg_state;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .dm_req_valid(dm_req_valid), .dm_req_we(dm_req_we), .dm_req_addr(dm_req_addr),
    .dm_req_wdata(dm_req_wdata), .dm_req_ready(dm_req_ready),
    .dm_rsp_valid(dm_rsp_valid), .dm_rsp_data(dm_rsp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  // Memory model: 256 words, data present only in the cycle MEM_LAT after mem_en.
  bit [31:0]   wmem [256];
  bit          wset [256];
  int          en_cyc = -100;
  logic [7:0]  en_addr = '0;

  function automatic logic [31:0] base_word(input logic [7:0] a);
    return (a == 8'h10) ? 32'hDEAD_BEEF : {24'hA50000, a};
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      en_cyc  <= cyc;
      en_addr <= mem_addr[7:0];
      if (mem_we) begin
        wmem[mem_addr[7:0]] <= mem_wdata;
        wset[mem_addr[7:0]] <= 1'b1;
      end
    end
  end

  always_comb begin
    mem_rdata = 32'hBAD0_BAD0;
    if (cyc == en_cyc + 2) mem_rdata = wset[en_addr] ? wmem[en_addr] : base_word(en_addr);
  end

  // ---------------- latency sweep DUTs (MEM_LAT=1 and 15) ----------------
  logic [1:0]  sw_v = '0;
  logic [31:0] sw_a = '0;
  logic [1:0]  sw_ready, sw_rsp_v, sw_dm_ready, sw_dm_rsp_v, sw_en, sw_we, sw_busy;
  logic [31:0] sw_rsp_d [2];
  logic [31:0] sw_dm_rsp_d [2];
  logic [31:0] sw_maddr [2];
  logic [31:0] sw_mwdata [2];
  logic [31:0] sw_rdata [2];
  logic [1:0]  sw_dbg [2];
  int          sw_en_cyc [2] = '{-100, -100};
  logic [7:0]  sw_en_addr [2] = '{8'h0, 8'h0};

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut_lat1 (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(sw_v[0]), .if_req_addr(sw_a), .if_req_ready(sw_ready[0]),
    .if_rsp_valid(sw_rsp_v[0]), .if_rsp_data(sw_rsp_d[0]),
    .dm_req_valid(1'b0), .dm_req_we(1'b0), .dm_req_addr(32'h0), .dm_req_wdata(32'h0),
    .dm_req_ready(sw_dm_ready[0]), .dm_rsp_valid(sw_dm_rsp_v[0]), .dm_rsp_data(sw_dm_rsp_d[0]),
    .mem_en(sw_en[0]), .mem_we(sw_we[0]), .mem_addr(sw_maddr[0]), .mem_wdata(sw_mwdata[0]),
    .mem_rdata(sw_rdata[0]), .busy(sw_busy[0]), .dbg_state(sw_dbg[0])
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(15), .STARVE_MAX(4)) dut_lat15 (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(sw_v[1]), .if_req_addr(sw_a), .if_req_ready(sw_ready[1]),
    .if_rsp_valid(sw_rsp_v[1]), .if_rsp_data(sw_rsp_d[1]),
    .dm_req_valid(1'b0), .dm_req_we(1'b0), .dm_req_addr(32'h0), .dm_req_wdata(32'h0),
    .dm_req_ready(sw_dm_ready[1]), .dm_rsp_valid(sw_dm_rsp_v[1]), .dm_rsp_data(sw_dm_rsp_d[1]),
    .mem_en(sw_en[1]), .mem_we(sw_we[1]), .mem_addr(sw_maddr[1]), .mem_wdata(sw_mwdata[1]),
    .mem_rdata(sw_rdata[1]), .busy(sw_busy[1]), .dbg_state(sw_dbg[1])
  );

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (sw_en[k]) begin
        sw_en_cyc[k]  <= cyc;
        sw_en_addr[k] <= sw_maddr[k][7:0];
      end
    end
  end

  always_comb begin
    sw_rdata[0] = (cyc == sw_en_cyc[0] + 1)  ? {24'hC0FFEE, sw_en_addr[0]} : 32'hBAD0_BAD0;
    sw_rdata[1] = (cyc == sw_en_cyc[1] + 15) ? {24'hC0FFEE, sw_en_addr[1]} : 32'hBAD0_BAD0;
  end

  // ---------------- driver tasks ----------------
  // Raise a request just after a rising edge, hold it until ready, drop it after the accept edge.
  task automatic send(input logic dm, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, output bit ok);
    @(posedge clk); #1;
    if (dm) begin
      dm_req_valid = 1'b1; dm_req_we = we; dm_req_addr = addr; dm_req_wdata = wdata;
    end else begin
      if_req_valid = 1'b1; if_req_addr = addr;
    end
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = dm ? dm_req_ready : if_req_ready;
    end
    @(posedge clk); #1;
    if_req_valid = 1'b0; dm_req_valid = 1'b0; dm_req_we = 1'b0;
  endtask

  // Counts cycles after the accept cycle until the owner's response pulse (-1 on timeout).
  task automatic wait_rsp(input logic dm, output int lat, output logic [31:0] data, output bit other);
    lat = -1; data = 'x; other = 1'b0;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(negedge clk);
      if ((dm ? if_rsp_valid : dm_rsp_valid) === 1'b1) other = 1'b1;
      if ((dm ? dm_rsp_valid : if_rsp_valid) === 1'b1) begin
        lat = n;
        data = dm ? dm_rsp_data : if_rsp_data;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [166:0] outs;
    #2;
    outs = {if_req_ready, if_rsp_valid, if_rsp_data, dm_req_ready, dm_rsp_valid, dm_rsp_data,
            mem_en, mem_we, mem_addr, mem_wdata, busy, dbg_state};
    tests_run++;
    if (outs !== '0) begin
      tests_failed++; $display("FAIL reset_outputs_during: got %h expected 0", outs);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    outs = {if_req_ready, if_rsp_valid, if_rsp_data, dm_req_ready, dm_rsp_valid, dm_rsp_data,
            mem_en, mem_we, mem_addr, mem_wdata, busy, dbg_state};
    tests_run++;
    if (outs !== '0) begin
      tests_failed++; $display("FAIL reset_outputs_after: got %h expected 0", outs);
    end
  endtask

  task automatic test_if_only();
    bit ok, other; int lat; logic [31:0] d;
    send(1'b0, 1'b0, 32'h10, 32'h0, ok);
    tests_run++;
    if (ok !== 1'b1) begin tests_failed++; $display("FAIL if_only_accept: got %b expected 1", ok); end
    #2;
    tests_run++;
    if ({mem_en, mem_we, mem_addr, dbg_state} !== {1'b1, 1'b0, 32'h10, ISSUE}) begin
      tests_failed++;
      $display("FAIL if_only_issue: en=%b we=%b addr=%h st=%0d expected en=1 we=0 addr=10 st=1",
               mem_en, mem_we, mem_addr, dbg_state);
    end
    wait_rsp(1'b0, lat, d, other);
    tests_run++;
    if (lat !== 4) begin tests_failed++; $display("FAIL if_only_latency: got %0d expected 4", lat); end
    tests_run++;
    if (d !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL if_only_data: got %h expected deadbeef", d); end
    tests_run++;
    if (other !== 1'b0) begin tests_failed++; $display("FAIL if_only_dm_quiet: got %b expected 0", other); end
    @(negedge clk);
    tests_run++;
    if ({if_rsp_valid, busy, if_rsp_data} !== {1'b0, 1'b0, 32'hDEAD_BEEF}) begin
      tests_failed++;
      $display("FAIL if_only_after: valid=%b busy=%b data=%h expected 0 0 deadbeef",
               if_rsp_valid, busy, if_rsp_data);
    end
  endtask

  task automatic test_store_load();
    bit ok, other; int lat; logic [31:0] d;
    send(1'b1, 1'b1, 32'h20, 32'h1234_5678, ok);
    tests_run++;
    if (ok !== 1'b1) begin tests_failed++; $display("FAIL store_accept: got %b expected 1", ok); end
    #2;
    tests_run++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h20, 32'h1234_5678}) begin
      tests_failed++;
      $display("FAIL store_issue: en=%b we=%b addr=%h wdata=%h expected 1 1 20 12345678",
               mem_en, mem_we, mem_addr, mem_wdata);
    end
    wait_rsp(1'b1, lat, d, other);
    tests_run++;
    if ({lat, d, other} !== {32'd4, 32'h0, 1'b0}) begin
      tests_failed++; $display("FAIL store_ack: lat=%0d data=%h if_pulse=%b expected 4 0 0", lat, d, other);
    end
    send(1'b1, 1'b0, 32'h20, 32'h0, ok);
    wait_rsp(1'b1, lat, d, other);
    tests_run++;
    if ({ok, lat, d, other} !== {1'b1, 32'd4, 32'h1234_5678, 1'b0}) begin
      tests_failed++;
      $display("FAIL load_back: ok=%b lat=%0d data=%h if_pulse=%b expected 1 4 12345678 0", ok, lat, d, other);
    end
  endtask

  task automatic test_simultaneous();
    int if_acc = -1, dm_at = -1, if_at = -1, dm_n = 0, if_n = 0;
    logic [31:0] dmd = 'x, ifd = 'x;
    @(posedge clk); #1;
    if_req_valid = 1'b1; if_req_addr = 32'h40;
    dm_req_valid = 1'b1; dm_req_we = 1'b0; dm_req_addr = 32'h44;
    @(negedge clk);
    tests_run++;
    if ({dm_req_ready, if_req_ready} !== 2'b10) begin
      tests_failed++; $display("FAIL simul_first_grant: dm_rdy=%b if_rdy=%b expected 1 0", dm_req_ready, if_req_ready);
    end
    @(posedge clk); #1;
    dm_req_valid = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (dm_rsp_valid) begin dm_n++; dm_at = n; dmd = dm_rsp_data; end
      if (if_rsp_valid) begin if_n++; if_at = n; ifd = if_rsp_data; end
      if (if_req_ready && if_acc < 0) begin
        if_acc = n;
        @(posedge clk); #1;
        if_req_valid = 1'b0;
      end
    end
    tests_run++;
    if ({if_acc, dm_at, if_at} !== {32'd5, 32'd4, 32'd9}) begin
      tests_failed++;
      $display("FAIL simul_timing: if_acc=%0d dm_rsp=%0d if_rsp=%0d expected 5 4 9", if_acc, dm_at, if_at);
    end
    tests_run++;
    if ({dm_n, if_n, dmd, ifd} !== {32'd1, 32'd1, 32'hA500_0044, 32'hA500_0040}) begin
      tests_failed++;
      $display("FAIL simul_routing: dm_pulses=%0d if_pulses=%0d dm=%h if=%h expected 1 1 a5000044 a5000040",
               dm_n, if_n, dmd, ifd);
    end
  endtask

  task automatic test_starvation();
    logic [0:0] exp_q [$];
    logic [0:0] got, exp;
    int last = -1, grants = 0;
    exp_q = '{OWN_DM, OWN_DM, OWN_DM, OWN_DM, OWN_IF, OWN_DM};
    @(posedge clk); #1;
    dm_req_valid = 1'b1; dm_req_we = 1'b0; dm_req_addr = 32'h50;
    if_req_valid = 1'b1; if_req_addr = 32'h60;
    for (int n = 0; n < 60 && grants < 6; n++) begin
      @(negedge clk);
      if (if_req_ready || dm_req_ready) begin
        got = dm_req_ready ? OWN_DM : OWN_IF;
        exp = exp_q.pop_front();
        tests_run++;
        if ({if_req_ready, dm_req_ready} === 2'b11 || got !== exp) begin
          tests_failed++;
          $display("FAIL starve_grant%0d: if_rdy=%b dm_rdy=%b expected owner %0d", grants,
                   if_req_ready, dm_req_ready, exp);
        end
        if (last >= 0) begin
          tests_run++;
          if (n - last !== 5) begin
            tests_failed++; $display("FAIL starve_spacing%0d: got %0d expected 5", grants, n - last);
          end
        end
        last = n;
        grants++;
      end
    end
    tests_run++;
    if (grants !== 6) begin tests_failed++; $display("FAIL starve_grant_count: got %0d expected 6", grants); end
    @(posedge clk); #1;
    dm_req_valid = 1'b0; if_req_valid = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok, other; int lat, pulses = 0; logic [31:0] d;
    logic [166:0] outs;
    send(1'b0, 1'b0, 32'h10, 32'h0, ok);
    @(posedge clk); #2;
    tests_run++;
    if ({ok, busy, mem_en, dbg_state} !== {1'b1, 1'b1, 1'b0, WAIT}) begin
      tests_failed++;
      $display("FAIL rst_mid_prewait: ok=%b busy=%b en=%b st=%0d expected 1 1 0 2", ok, busy, mem_en, dbg_state);
    end
    rst_n = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    #1;
    outs = {if_req_ready, if_rsp_valid, if_rsp_data, dm_req_ready, dm_rsp_valid, dm_rsp_data,
            mem_en, mem_we, mem_addr, mem_wdata, busy, dbg_state};
    tests_run++;
    if (outs !== '0) begin tests_failed++; $display("FAIL rst_mid_outputs: got %h expected 0", outs); end
    if_req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (if_rsp_valid || dm_rsp_valid) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin tests_failed++; $display("FAIL rst_mid_no_rsp: got %0d pulses expected 0", pulses); end
    send(1'b0, 1'b0, 32'h10, 32'h0, ok);
    wait_rsp(1'b0, lat, d, other);
    tests_run++;
    if ({ok, lat, d, other} !== {1'b1, 32'd4, 32'hDEAD_BEEF, 1'b0}) begin
      tests_failed++;
      $display("FAIL rst_mid_recover: ok=%b lat=%0d data=%h dm_pulse=%b expected 1 4 deadbeef 0", ok, lat, d, other);
    end
  endtask

  task automatic test_lat_sweep();
    int lat_of [2] = '{1, 15};
    bit acc; int lat; logic [31:0] d, exp_d;
    logic [139:0] quiet;
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 3; r++) begin
        @(posedge clk); #1;
        sw_v[k] = 1'b1;
        sw_a = 32'h80 + 32'(r) * 4;
        exp_d = 32'hC0FF_EE00 | (32'h80 + 32'(r) * 4);
        acc = 1'b0;
        for (int n = 0; n < 50 && !acc; n++) begin
          @(negedge clk);
          acc = sw_ready[k];
        end
        @(posedge clk); #1;
        sw_v[k] = 1'b0;
        lat = -1; d = 'x;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
          @(negedge clk);
          if (sw_rsp_v[k]) begin lat = n; d = sw_rsp_d[k]; end
        end
        tests_run++;
        if ({acc, lat, d} !== {1'b1, 32'(lat_of[k] + 2), exp_d}) begin
          tests_failed++;
          $display("FAIL sweep_lat%0d_req%0d: acc=%b lat=%0d data=%h expected 1 %0d %h",
                   lat_of[k], r, acc, lat, d, lat_of[k] + 2, exp_d);
        end
      end
    end
    @(negedge clk);
    quiet = {sw_dm_ready, sw_dm_rsp_v, sw_en, sw_we, sw_busy, sw_dm_rsp_d[0], sw_dm_rsp_d[1],
             sw_mwdata[0], sw_mwdata[1], sw_dbg[0], sw_dbg[1]};
    tests_run++;
    if (quiet !== '0) begin tests_failed++; $display("FAIL sweep_quiet: got %h expected 0", quiet); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_if_only();
    test_store_load();
    test_simultaneous();
    test_starvation();
    test_reset_mid();
    test_lat_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", tests_run);
    $fatal(1, "watchdog");
  end

endmodule
